// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD frame scanner: HD44780 command constants,
// the scanner state encoding and the buffer-index -> DDRAM-address mapping.
package lcd_pkg;

    localparam logic [7:0] LCD_CMD_SET_DDRAM = 8'h80;
    localparam logic [7:0] LCD_LINE2_BASE    = 8'h40;
    localparam logic [7:0] LCD_BLANK         = 8'h20;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SCAN      = 2'd1,
        ST_SEND_ADDR = 2'd2,
        ST_SEND_CHAR = 2'd3
    } scan_state_e;

    // Buffer index 0..cols-1 is row 0, cols..2*cols-1 is row 1.
    function automatic logic [7:0] ddram_addr(input int unsigned idx,
                                              input int unsigned cols,
                                              input logic [7:0]  line2_base);
        logic [7:0] addr;
        if (idx >= cols) begin
            addr = line2_base + 8'(idx - cols);
        end else begin
            addr = 8'(idx);
        end
        return addr;
    endfunction

endpackage

// File: rtl/lcd_frame_ram.sv
// Character frame storage with per-entry dirty bits.
// Ports: clk/rst; host write (i_wr_en/i_wr_addr/i_wr_data, out-of-range
// ignored); one read port (i_rd_addr -> o_rd_data, o_rd_dirty); dirty clear
// strobe i_clr_en acting on i_rd_addr (a host write to the same entry on the
// same edge wins); o_any_dirty summary.
module lcd_frame_ram
    import lcd_pkg::*;
#(
    parameter  int DEPTH = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [7:0]    i_wr_data,
    input  logic [AW-1:0] i_rd_addr,
    output logic [7:0]    o_rd_data,
    output logic          o_rd_dirty,
    input  logic          i_clr_en,
    output logic          o_any_dirty
);

    logic [7:0]       r_mem [DEPTH];
    logic [DEPTH-1:0] r_dirty;
    logic             w_wr_ok;

    assign w_wr_ok     = i_wr_en && ({1'b0, i_wr_addr} < (AW+1)'(DEPTH));
    assign o_rd_data   = r_mem[i_rd_addr];
    assign o_rd_dirty  = r_dirty[i_rd_addr];
    assign o_any_dirty = |r_dirty;

    // Storage and dirty tracking; reset blanks the frame and marks it all dirty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= LCD_BLANK;
            end
            r_dirty <= '1;
        end else begin
            if (w_wr_ok) begin
                r_mem[i_wr_addr] <= i_wr_data;
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (w_wr_ok && (i_wr_addr == AW'(i))) begin
                    r_dirty[i] <= 1'b1;
                end else if (i_clr_en && (i_rd_addr == AW'(i))) begin
                    r_dirty[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/lcd_frame_scanner.sv
// Scans a 2 x COLS character frame buffer and streams changed characters to
// the HD44780 write engine as set-DDRAM-address / character-write commands.
// Ports: clk, rst (async, active-high); host write wr_en/wr_addr/wr_data;
// lcd_ready enables scanning; command stream cmd_valid/cmd_rs/cmd_data with
// cmd_ready handshake; busy = any entry dirty or scanner not idle.
module lcd_frame_scanner
    import lcd_pkg::*;
#(
    parameter  int         COLS       = 16,
    parameter  logic [7:0] LINE2_BASE = LCD_LINE2_BASE,
    localparam int         DEPTH      = 2 * COLS,
    localparam int         AW         = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          lcd_ready,
    output logic          cmd_valid,
    output logic          cmd_rs,
    output logic [7:0]    cmd_data,
    input  logic          cmd_ready,
    output logic          busy
);

    scan_state_e   r_state, w_state_nxt;
    logic [AW-1:0] r_scan_ptr, w_scan_ptr_nxt;
    logic [AW-1:0] r_idx, w_idx_nxt;
    logic [7:0]    r_cur_pos, w_cur_pos_nxt;
    logic          r_cur_valid, w_cur_valid_nxt;
    logic          r_cmd_valid, w_cmd_valid_nxt;
    logic          r_cmd_rs, w_cmd_rs_nxt;
    logic [7:0]    r_cmd_data, w_cmd_data_nxt;

    logic [AW-1:0] w_rd_addr;
    logic [7:0]    w_rd_data;
    logic          w_rd_dirty;
    logic          w_any_dirty;
    logic          w_clr_en;
    logic [7:0]    w_addr;
    logic          w_accept;
    logic [AW-1:0] w_ptr_inc;
    logic [AW-1:0] w_idx_inc;
    logic          w_row_end;

    // While scanning, the read port looks at the scan pointer; otherwise it
    // stays on the entry being sent, so the clear always targets that entry.
    assign w_rd_addr = (r_state == ST_SCAN) ? r_scan_ptr : r_idx;
    assign w_addr    = ddram_addr(32'(w_rd_addr), 32'(COLS), LINE2_BASE);
    assign w_accept  = r_cmd_valid && cmd_ready;
    assign w_ptr_inc = (r_scan_ptr == AW'(DEPTH - 1)) ? '0 : r_scan_ptr + AW'(1);
    assign w_idx_inc = (r_idx == AW'(DEPTH - 1)) ? '0 : r_idx + AW'(1);
    assign w_row_end = (r_idx == AW'(COLS - 1)) || (r_idx == AW'(DEPTH - 1));

    lcd_frame_ram #(.DEPTH(DEPTH)) u_ram (
        .clk         (clk),
        .rst         (rst),
        .i_wr_en     (wr_en),
        .i_wr_addr   (wr_addr),
        .i_wr_data   (wr_data),
        .i_rd_addr   (w_rd_addr),
        .o_rd_data   (w_rd_data),
        .o_rd_dirty  (w_rd_dirty),
        .i_clr_en    (w_clr_en),
        .o_any_dirty (w_any_dirty)
    );

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_scan_ptr  <= '0;
            r_idx       <= '0;
            r_cur_pos   <= 8'h00;
            r_cur_valid <= 1'b0;
            r_cmd_valid <= 1'b0;
            r_cmd_rs    <= 1'b0;
            r_cmd_data  <= 8'h00;
        end else begin
            r_state     <= w_state_nxt;
            r_scan_ptr  <= w_scan_ptr_nxt;
            r_idx       <= w_idx_nxt;
            r_cur_pos   <= w_cur_pos_nxt;
            r_cur_valid <= w_cur_valid_nxt;
            r_cmd_valid <= w_cmd_valid_nxt;
            r_cmd_rs    <= w_cmd_rs_nxt;
            r_cmd_data  <= w_cmd_data_nxt;
        end
    end

    // Next-state and command generation.
    always_comb begin
        w_state_nxt     = r_state;
        w_scan_ptr_nxt  = r_scan_ptr;
        w_idx_nxt       = r_idx;
        w_cur_pos_nxt   = r_cur_pos;
        w_cur_valid_nxt = r_cur_valid;
        w_cmd_valid_nxt = r_cmd_valid;
        w_cmd_rs_nxt    = r_cmd_rs;
        w_cmd_data_nxt  = r_cmd_data;
        w_clr_en        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!lcd_ready) begin
                    w_cur_valid_nxt = 1'b0;
                end else if (w_any_dirty) begin
                    w_state_nxt = ST_SCAN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (!lcd_ready) begin
                    w_state_nxt     = ST_IDLE;
                    w_cur_valid_nxt = 1'b0;
                end else if (!w_any_dirty) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_rd_dirty) begin
                    w_idx_nxt       = r_scan_ptr;
                    w_cmd_valid_nxt = 1'b1;
                    // Cursor already sits on this cell: skip the address command.
                    if (r_cur_valid && (r_cur_pos == w_addr)) begin
                        w_state_nxt    = ST_SEND_CHAR;
                        w_cmd_rs_nxt   = 1'b1;
                        w_cmd_data_nxt = w_rd_data;
                        w_clr_en       = 1'b1;
                    end else begin
                        w_state_nxt    = ST_SEND_ADDR;
                        w_cmd_rs_nxt   = 1'b0;
                        w_cmd_data_nxt = LCD_CMD_SET_DDRAM | w_addr;
                    end
                end else begin
                    w_scan_ptr_nxt = w_ptr_inc;
                end
            end
            ST_SEND_ADDR: begin
                // The character command is issued on the same edge the address
                // is accepted, so cmd_valid stays high across the pair.
                if (w_accept) begin
                    w_cur_pos_nxt   = w_addr;
                    w_cur_valid_nxt = 1'b1;
                    w_state_nxt     = ST_SEND_CHAR;
                    w_cmd_rs_nxt    = 1'b1;
                    w_cmd_data_nxt  = w_rd_data;
                    w_clr_en        = 1'b1;
                end else begin
                    w_state_nxt = ST_SEND_ADDR;
                end
            end
            ST_SEND_CHAR: begin
                if (w_accept) begin
                    w_cur_pos_nxt   = r_cur_pos + 8'd1;
                    // The LCD cursor does not wrap from the end of row 0 into
                    // row 1, so force an address command for the next cell.
                    if (w_row_end) begin
                        w_cur_valid_nxt = 1'b0;
                    end else begin
                        w_cur_valid_nxt = r_cur_valid;
                    end
                    w_scan_ptr_nxt  = w_idx_inc;
                    w_cmd_valid_nxt = 1'b0;
                    w_state_nxt     = ST_SCAN;
                end else begin
                    w_state_nxt = ST_SEND_CHAR;
                end
            end
            default: begin
                w_state_nxt     = ST_IDLE;
                w_cmd_valid_nxt = 1'b0;
            end
        endcase
    end

    assign cmd_valid = r_cmd_valid;
    assign cmd_rs    = r_cmd_rs;
    assign cmd_data  = r_cmd_data;
    assign busy      = w_any_dirty || (r_state != ST_IDLE);

endmodule

// File: tb/tb_lcd_frame_scanner.sv
module tb_lcd_frame_scanner;

    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          lcd_ready;
    logic          cmd_valid;
    logic          cmd_rs;
    logic [7:0]    cmd_data;
    logic          cmd_ready;
    logic          busy;

    int checks = 0;
    int errors = 0;
    logic [8:0] exp_q [$];

    lcd_frame_scanner #(.COLS(16), .LINE2_BASE(8'h40)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .lcd_ready (lcd_ready),
        .cmd_valid (cmd_valid),
        .cmd_rs    (cmd_rs),
        .cmd_data  (cmd_data),
        .cmd_ready (cmd_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic rs, input logic [7:0] data);
        exp_q.push_back({rs, data});
    endtask

    task automatic push_blank();
        push(1'b0, 8'h80);
        for (int i = 0; i < 16; i++) push(1'b1, 8'h20);
        push(1'b0, 8'hC0);
        for (int i = 0; i < 16; i++) push(1'b1, 8'h20);
    endtask

    task automatic host_write(input logic [AW-1:0] a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while (((exp_q.size() != 0) || busy) && (n < budget)) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({"drain_", tag}, {31'd0, (exp_q.size() == 0) && !busy}, 32'd1);
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n = 0;
        while (!cmd_valid && (n < budget)) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({"valid_", tag}, {31'd0, cmd_valid}, 32'd1);
    endtask

    // Scoreboard: every transfer seen on the command port is popped and compared.
    always @(negedge clk) begin
        if (!rst && cmd_valid && cmd_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_xfer", {23'd0, cmd_rs, cmd_data}, 32'h1FF);
            end else begin
                chk("xfer", {23'd0, cmd_rs, cmd_data}, {23'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        rst       = 1'b1;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = 8'h00;
        lcd_ready = 1'b0;
        cmd_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, cmd_valid}, 32'd0);
        chk("rst_rs",    {31'd0, cmd_rs},    32'd0);
        chk("rst_data",  {24'd0, cmd_data},  32'd0);
        chk("rst_busy",  {31'd0, busy},      32'd1);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("idle_not_ready_valid", {31'd0, cmd_valid}, 32'd0);
        chk("idle_not_ready_busy",  {31'd0, busy},      32'd1);

        // Full blank refresh after reset.
        push_blank();
        lcd_ready = 1'b1;
        wait_drain("blank", 500);
        chk("blank_busy_low", {31'd0, busy}, 32'd0);

        // Single character.
        push(1'b0, 8'h85);
        push(1'b1, 8'h41);
        host_write(5'd5, 8'h41);
        wait_drain("single", 200);

        // Consecutive cells in one row: one address then three characters.
        push(1'b0, 8'h83);
        push(1'b1, 8'h61);
        push(1'b1, 8'h62);
        push(1'b1, 8'h63);
        host_write(5'd3, 8'h61);
        host_write(5'd4, 8'h62);
        host_write(5'd5, 8'h63);
        wait_drain("run", 200);

        // Row boundary: cursor must be re-addressed for row 1.
        push(1'b0, 8'h8F);
        push(1'b1, 8'h4F);
        push(1'b0, 8'hC0);
        push(1'b1, 8'h50);
        host_write(5'd15, 8'h4F);
        host_write(5'd16, 8'h50);
        wait_drain("rowend", 200);

        // Stall in SEND_CHAR for addr 2 with a host write during the stall.
        cmd_ready = 1'b0;
        push(1'b0, 8'h82);
        push(1'b1, 8'h33);
        host_write(5'd2, 8'h33);
        wait_valid("stall_addr", 100);
        chk("stall_addr_cmd", {23'd0, cmd_rs, cmd_data}, {23'd0, 9'h082});
        cmd_ready = 1'b1;
        @(posedge clk);
        #1;
        cmd_ready = 1'b0;
        host_write(5'd2, 8'h5A);
        for (int i = 0; i < 20; i++) begin
            chk("stall_hold", {22'd0, cmd_valid, cmd_rs, cmd_data}, {22'd0, 10'h333});
            @(posedge clk);
            #1;
        end
        push(1'b0, 8'h82);
        push(1'b1, 8'h5A);
        cmd_ready = 1'b1;
        wait_drain("stall", 300);

        // lcd_ready drop while a command is pending: it must not be withdrawn.
        cmd_ready = 1'b0;
        host_write(5'd7, 8'h77);
        wait_valid("drop", 100);
        lcd_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("drop_hold", {22'd0, cmd_valid, cmd_rs, cmd_data}, {22'd0, 10'h287});
        end
        push(1'b0, 8'h87);
        push(1'b1, 8'h77);
        cmd_ready = 1'b1;
        wait_drain("drop", 200);

        // Async reset mid-stream, then a complete blank refresh again.
        lcd_ready = 1'b1;
        cmd_ready = 1'b0;
        host_write(5'd10, 8'h4B);
        wait_valid("prerst", 100);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", {31'd0, cmd_valid}, 32'd0);
        chk("async_rst_busy",  {31'd0, busy},      32'd1);
        chk("async_rst_data",  {24'd0, cmd_data},  32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        push_blank();
        cmd_ready = 1'b1;
        wait_drain("reblank", 500);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
